deshift_reg_file: RTL
=====================

DESHIFT_REG_FILE -- requirements
Module: deshift_reg_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per word per lane; legal range is 2 or more.
REQ-002 SHALL have parameter VEC_LENGTH, default 16, number of independent lanes.
REQ-003 SHALL have port clk, input, 1 bit, the clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port d_in, input, array [VEC_LENGTH] of 1 bit, serial bit per lane, MSB-first.
REQ-006 SHALL have port in_valid, input, 1 bit: d_in carries a valid bit slice this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the bit slice this cycle.
REQ-008 SHALL have port clear, input, 1 bit: discard the partially assembled word.
REQ-009 SHALL have port d_out, output, array [VEC_LENGTH] of DATA_WIDTH bits: assembled words.
REQ-010 SHALL have port out_valid, output, 1 bit: d_out holds a complete word set.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes d_out this cycle.
REQ-012 SHALL have port busy, output, 1 bit: a partial word is in progress (bit count nonzero).

Function
REQ-013 A bit slice SHALL be accepted exactly when in_valid && in_ready && !clear.
REQ-014 On accept, each lane j SHALL update as shift_reg[j] <= {shift_reg[j][DATA_WIDTH-2:0], d_in[j]}, and the bit counter SHALL increment.
REQ-015 Bit counter width SHALL be clog2(DATA_WIDTH); counter SHALL wrap to 0 after the accept at count DATA_WIDTH-1.
REQ-016 On the accept at count DATA_WIDTH-1, the completed word (including the current bit) SHALL load into the output register; out_valid SHALL be 1 the next cycle (latency 1 from last bit).
REQ-017 The output buffer SHALL be a 2-state FSM: OUT_EMPTY -> OUT_FULL on word completion; OUT_FULL -> OUT_EMPTY on out_ready with no completion in the same cycle; OUT_FULL stays OUT_FULL on simultaneous out_ready and completion, with the new word loaded.
REQ-018 d_out SHALL remain stable while out_valid && !out_ready.
REQ-019 in_ready SHALL be 0 only when count == DATA_WIDTH-1 && out_valid && !out_ready; otherwise 1. Non-final bits SHALL never stall.
REQ-020 in_ready SHALL be a combinational function of out_ready and state; no other combinational input-to-output paths.
REQ-021 clear SHALL zero the counter and all shift_reg lanes next cycle, SHALL override a same-cycle accept, and SHALL NOT affect the output register or out_valid.
REQ-022 d_out SHALL be meaningless when out_valid is 0, but SHALL retain its last value (no zeroing on drain).
REQ-023 busy SHALL be 1 iff the counter is nonzero.

Reset
REQ-024 On reset: counter = 0, shift_reg = 0, output register = 0, FSM = OUT_EMPTY; hence out_valid = 0, busy = 0, in_ready = 1.
REQ-025 Reset asserted mid-word or with out_valid high SHALL discard all data without emitting a word; reset overrides clear and accept.

Structure
REQ-026 A shared package SHALL hold the output FSM state typedef (OUT_EMPTY, OUT_FULL) and the default DATA_WIDTH/VEC_LENGTH constants used across the bit-serial datapath.
REQ-027 The per-lane shift-in register SHALL be a sub-module shift_in_lane (DATA_WIDTH-bit, enable and clear inputs), instantiated VEC_LENGTH times via generate; the counter and FSM SHALL live in the top module.

Verification (DATA_WIDTH=8, VEC_LENGTH=16)
REQ-028 Lane 0 bits 1,0,1,0,0,1,0,1 on 8 consecutive accepts, out_ready=1 -> d_out[0]=0xA5, out_valid high exactly 1 cycle after the 8th accept; lane 15 fed all 1s -> 0xFF.
REQ-029 Two back-to-back words 0x3C then 0xC3, out_ready held 0 -> in_ready=0 on the 8th bit of word 2, d_out stays 0x3C; raise out_ready -> in_ready=1 the same cycle, 0xC3 appears next cycle.
REQ-030 out_ready=1 on the same cycle as the last-bit accept of the next word -> out_valid stays 1 with no bubble, new word presented.
REQ-031 Feed 5 bits, assert clear, then feed 0x81 -> d_out[0]=0x81, busy=0 on the clear cycle+1, and the pending output is unaffected.
REQ-032 Reset asserted after 4 bits with out_valid=1 -> next cycle out_valid=0, busy=0, in_ready=1; a subsequent full word assembles correctly.
REQ-033 in_valid toggled randomly (gaps of 0-3 cycles) -> assembled word identical to gapless feeding.

Source files
------------

// File: rtl/deshift_reg_file_pkg.sv
// Shared types and default sizes for the bit-serial deshift register file.
package deshift_reg_file_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_VEC_LENGTH = 16;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/deshift_reg_file_shift_in_lane.sv
// One lane of the deshifter: MSB-first serial-to-parallel shift register.
module shift_in_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  d_in,
    output logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] q_next
);

    logic [DATA_WIDTH-1:0] shift_reg;

    // Word including the bit being shifted in this cycle, so the top can
    // capture a completed word on its final accept.
    assign q_next = {shift_reg[DATA_WIDTH-2:0], d_in};
    assign q      = shift_reg;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            shift_reg <= '0;
        end else if (en) begin
            shift_reg <= q_next;
        end
    end

endmodule

// File: rtl/deshift_reg_file.sv
// Bit-serial to parallel deshifter for VEC_LENGTH lanes with a one-word
// output buffer and ready/valid handshakes on both sides.
module deshift_reg_file
    import deshift_reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int VEC_LENGTH = DEFAULT_VEC_LENGTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VEC_LENGTH-1:0] d_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] d_out [VEC_LENGTH],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic [CNT_W-1:0]      count_reg;
    out_state_t            state_reg;
    logic [DATA_WIDTH-1:0] out_reg    [VEC_LENGTH];
    logic [DATA_WIDTH-1:0] lane_q     [VEC_LENGTH];
    logic [DATA_WIDTH-1:0] lane_next  [VEC_LENGTH];

    logic last_bit;
    logic accept;
    logic complete;

    assign last_bit  = (count_reg == LAST_CNT);
    // Only the final bit of a word can stall, and only when the buffer
    // still holds a word the consumer is not taking this cycle.
    assign in_ready  = !(last_bit && (state_reg == OUT_FULL) && !out_ready);
    assign accept    = in_valid && in_ready && !clear;
    assign complete  = accept && last_bit;
    assign out_valid = (state_reg == OUT_FULL);
    assign busy      = (count_reg != '0);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (accept) begin
            count_reg <= last_bit ? '0 : count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= OUT_EMPTY;
        end else begin
            case (state_reg)
                OUT_EMPTY: if (complete) state_reg <= OUT_FULL;
                OUT_FULL:  if (out_ready && !complete) state_reg <= OUT_EMPTY;
                default:   state_reg <= OUT_EMPTY;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < VEC_LENGTH; gi++) begin : g_lane
            shift_in_lane #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_lane (
                .clk    (clk),
                .reset  (reset),
                .en     (accept),
                .clr    (clear),
                .d_in   (d_in[gi]),
                .q      (lane_q[gi]),
                .q_next (lane_next[gi])
            );

            // Output word holds its value after draining; only a new word
            // or reset changes it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_reg[gi] <= '0;
                end else if (complete) begin
                    out_reg[gi] <= lane_next[gi];
                end
            end

            assign d_out[gi] = out_reg[gi];
        end
    endgenerate

endmodule
